// File: rtl/syscall_handler.sv
// Console syscall service unit: print_char, print_string, exit, optional print_int.
// Define SYSCALL_PRINT_INT_EN to enable code 1 (print_int as 8 uppercase hex digits).
module syscall_handler (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        stall,
    output logic        done,
    output logic        halt,
    output logic        err
);

    localparam logic [31:0] CodePrintInt    = 32'd1;
    localparam logic [31:0] CodePrintString = 32'd4;
    localparam logic [31:0] CodeExit        = 32'd10;
    localparam logic [31:0] CodePrintChar   = 32'd11;
    localparam logic [7:0]  MaxStrBytes     = 8'd255;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StEmit,
`ifdef SYSCALL_PRINT_INT_EN
        StHex,
`endif
        StDone,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        err_q, err_d;
    logic [7:0]  rd_byte;

`ifdef SYSCALL_PRINT_INT_EN
    logic [2:0]  nib_q, nib_d;
    logic [3:0]  hex_nib;
    logic [31:0] hex_shifted;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            err_q   <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
            nib_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
`ifdef SYSCALL_PRINT_INT_EN
            nib_q   <= nib_d;
`endif
        end
    end

    // Little-endian byte lane selected by the low pointer bits.
    always_comb begin
        case (ptr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
    end

`ifdef SYSCALL_PRINT_INT_EN
    // ~nib_q == 7 - nib_q, so digit 0 is the most significant nibble.
    always_comb begin
        hex_shifted = ptr_q >> {~nib_q, 2'b00};
        hex_nib     = hex_shifted[3:0];
    end
`endif

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        err_d     = err_q;
`ifdef SYSCALL_PRINT_INT_EN
        nib_d     = nib_q;
`endif
        mem_rd    = 1'b0;
        out_valid = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        halt      = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall = syscall & ~rst;
                if (syscall) begin
                    code_d = v0;
                    ptr_d  = a0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
                    nib_d  = '0;
`endif
                    if (v0 == CodePrintChar) begin
                        byte_d  = a0[7:0];
                        state_d = StEmit;
                    end else if (v0 == CodePrintString) begin
                        state_d = StFetch;
                    end else if (v0 == CodeExit) begin
                        state_d = StHalt;
`ifdef SYSCALL_PRINT_INT_EN
                    end else if (v0 == CodePrintInt) begin
                        state_d = StHex;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StFetch: begin
                stall   = 1'b1;
                mem_rd  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                stall = 1'b1;
                if (rd_byte == 8'h00) begin
                    state_d = StDone;
                end else begin
                    byte_d  = rd_byte;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                stall     = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (code_q == CodePrintString) begin
                        ptr_d = ptr_q + 32'd1;
                        cnt_d = cnt_q + 8'd1;
                        // Truncate after the 255th byte; the counter never wraps.
                        if (cnt_d == MaxStrBytes) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            state_d = StFetch;
                        end
`ifdef SYSCALL_PRINT_INT_EN
                    end else if (code_q == CodePrintInt) begin
                        if (nib_q == 3'd7) begin
                            state_d = StDone;
                        end else begin
                            nib_d   = nib_q + 3'd1;
                            state_d = StHex;
                        end
`endif
                    end else begin
                        state_d = StDone;
                    end
                end
            end
`ifdef SYSCALL_PRINT_INT_EN
            StHex: begin
                stall   = 1'b1;
                byte_d  = (hex_nib < 4'd10) ? (8'h30 + {4'h0, hex_nib})
                                            : (8'h37 + {4'h0, hex_nib});
                state_d = StEmit;
            end
`endif
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
            StHalt: begin
                stall = 1'b1;
                halt  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_addr = {ptr_q[31:2], 2'b00};
    assign out_data = byte_q;

endmodule

// File: tb/tb_syscall_handler.sv
// Scoreboard bench for syscall_handler: expected bytes, read addresses and done/err
// outcomes are queued by the stimulus and consumed by a negedge monitor.
module tb_syscall_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall;
    logic [31:0] v0, a0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        stall, done, halt, err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int exp_done_n = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addrs[$];
    logic        exp_errs[$];

    syscall_handler dut (
        .clk       (clk),
        .rst       (rst),
        .syscall   (syscall),
        .v0        (v0),
        .a0        (a0),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall     (stall),
        .done      (done),
        .halt      (halt),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h0043_4241;
            32'h0000_0200: return 32'h0000_4948;
            32'h0000_0300: return 32'h0000_0041;
            32'hFFFF_FFFC: return 32'h5A00_0000;
            default:       return (addr >= 32'h1000 && addr < 32'h2000) ? 32'h0101_0101 : 32'h0;
        endcase
    endfunction

    always @(posedge clk) if (mem_rd) mem_rdata <= mem_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    // Monitor: consumes scoreboard queues whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_bytes.size() == 0) fail("unexpected byte", {24'h0, out_data});
                else chk("out_data", {24'h0, out_data}, {24'h0, exp_bytes.pop_front()});
            end
            if (mem_rd) begin
                if (exp_addrs.size() == 0) fail("unexpected mem_rd", mem_addr);
                else chk("mem_addr", mem_addr, exp_addrs.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("stall in done", {31'h0, stall}, 32'h0);
                if (exp_errs.size() == 0) fail("unexpected done", {31'h0, err});
                else chk("err on done", {31'h0, err}, {31'h0, exp_errs.pop_front()});
            end else if (err) begin
                fail("err without done", {31'h0, err});
            end
        end
    end

    task automatic expect_done(input logic e);
        exp_errs.push_back(e);
        exp_done_n++;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
    endtask

    task automatic issue(input logic [31:0] code, input logic [31:0] arg);
        @(posedge clk); #1;
        v0 = code; a0 = arg; syscall = 1'b1;
        @(posedge clk); #1;
        syscall = 1'b0;
        v0 = 32'd11;      // later register changes must not disturb the service
        a0 = 32'h0;
    endtask

    task automatic wait_done(input int bound);
        int i = 0;
        while (done_cnt < exp_done_n && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (done_cnt < exp_done_n) fail("done timeout", done_cnt);
    endtask

    initial begin
        rst = 1'b1; syscall = 1'b0; v0 = '0; a0 = '0; out_ready = 1'b1;
        #1;
        chk("reset stall", {31'h0, stall}, 32'h0);
        chk("reset outputs", {28'h0, mem_rd, out_valid, done, halt}, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset out_data", {24'h0, out_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // print_char
        exp_bytes.push_back(8'h41); expect_done(1'b0);
        issue(32'd11, 32'h41);
        wait_done(20);

        // print_string with unaligned start and NUL in the same word
        exp_addrs.push_back(32'h100); exp_addrs.push_back(32'h100);
        push_str("C"); expect_done(1'b0);
        issue(32'd4, 32'h102);
        wait_done(40);

        // print_string with backpressure on the first byte
        exp_addrs.push_back(32'h200); exp_addrs.push_back(32'h200); exp_addrs.push_back(32'h200);
        push_str("HI"); expect_done(1'b0);
        out_ready = 1'b0;
        issue(32'd4, 32'h200);
        begin
            int i = 0;
            while (!out_valid && i < 20) begin @(negedge clk); i++; end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("held valid", {31'h0, out_valid}, 32'h1);
            chk("held data", {24'h0, out_data}, 32'h48);
            chk("no extra rd", {31'h0, mem_rd}, 32'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(40);

        // unsupported code
        expect_done(1'b1);
        issue(32'd99, 32'h55);
        wait_done(20);

        // print_int
`ifdef SYSCALL_PRINT_INT_EN
        push_str("DEADBEEF"); expect_done(1'b0);
`else
        expect_done(1'b1);
`endif
        issue(32'd1, 32'hDEAD_BEEF);
        wait_done(60);

        // pointer wrap 0xFFFFFFFF -> 0
        exp_addrs.push_back(32'hFFFF_FFFC); exp_addrs.push_back(32'h0);
        push_str("Z"); expect_done(1'b0);
        issue(32'd4, 32'hFFFF_FFFF);
        wait_done(40);

        // 255-byte truncation guard
        for (int i = 0; i < 255; i++) begin
            exp_addrs.push_back((32'h1000 + i) & 32'hFFFF_FFFC);
            exp_bytes.push_back(8'h01);
        end
        expect_done(1'b1);
        issue(32'd4, 32'h1000);
        wait_done(2000);

        // asynchronous reset mid-EMIT
        exp_addrs.push_back(32'h300);
        out_ready = 1'b0;
        issue(32'd4, 32'h300);
        begin
            int i = 0;
            while (!out_valid && i < 20) begin @(negedge clk); i++; end
        end
        chk("emit before rst", {31'h0, out_valid}, 32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst stall", {31'h0, stall}, 32'h0);
        chk("rst out_data", {24'h0, out_data}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        expect_done(1'b1);
        issue(32'd99, 32'h0);
        wait_done(20);

        // exit: sticky halt while syscall toggles
        issue(32'd10, 32'h0);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            syscall = 1'($urandom_range(0, 1));
            v0 = 32'd11;
            @(negedge clk);
            chk("halt sticky", {30'h0, halt, stall}, 32'h3);
        end
        @(posedge clk); #1;
        syscall = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt cleared", {31'h0, halt}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bytes left", exp_bytes.size(), 32'h0);
        chk("addrs left", exp_addrs.size(), 32'h0);
        chk("dones left", exp_errs.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/syscall_handler.md
SYSCALL_HANDLER -- requirements
Module: syscall_handler

Interface
REQ-001 clk  input  1  single clock; all state changes on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 syscall  input  1  level from the syscall detector, high while the current instruction is 0x0000000C.
REQ-004 v0  input  32  register $v0 (service code), sampled at syscall acceptance.
REQ-005 a0  input  32  register $a0 (argument/pointer), sampled at syscall acceptance.
REQ-006 mem_rd  output  1  one-cycle data-memory read request.
REQ-007 mem_addr  output  32  word-aligned read address, {ptr[31:2],2'b00}.
REQ-008 mem_rdata  input  32  read data, valid the cycle after mem_rd.
REQ-009 out_valid  output  1  console byte valid.
REQ-010 out_data  output  8  console ASCII byte.
REQ-011 out_ready  input  1  console accepts byte when out_valid && out_ready at posedge.
REQ-012 stall  output  1  holds PC/register writes while a syscall is serviced.
REQ-013 done  output  1  one-cycle pulse, service complete.
REQ-014 halt  output  1  sticky; program exited.
REQ-015 err  output  1  one-cycle pulse with done on unsupported code or truncated string.

Function
REQ-016 States: IDLE, FETCH, WAIT, EMIT, HEX, DONE, HALT.
REQ-017 IDLE: syscall=1 at posedge latches code=v0, ptr=a0; next state by code; syscall=0 stays IDLE.
REQ-018 stall = syscall in IDLE; 1 in FETCH, WAIT, EMIT, HEX, HALT; 0 in DONE.
REQ-019 Code 11 (print_char): EMIT a0[7:0] once, then DONE.
REQ-020 Code 4 (print_string): FETCH asserts mem_rd one cycle; WAIT selects byte mem_rdata[8*ptr[1:0]+:8] (little-endian); byte 0x00 -> DONE; else EMIT, ptr+1, count+1, back to FETCH after handshake.
REQ-021 String guard: after 255 emitted bytes without NUL -> DONE with err=1; byte counter 8 bits, never wraps.
REQ-022 Code 10 (exit): -> HALT; halt=1 and stall=1 until reset; syscall ignored in HALT; no done pulse.
REQ-023 Any other code (incl. 1 when REQ-031 disabled): DONE with err=1, no output bytes.
REQ-024 EMIT: out_valid held with stable out_data until out_ready; out_ready=1 same cycle out_valid rises completes in that cycle; out_valid=0 in all other states.
REQ-025 DONE lasts exactly one cycle (done=1, stall=0), then IDLE; syscall resampled in IDLE, so back-to-back syscalls are serviced separately.
REQ-026 Pointer arithmetic modulo 2^32; wrap from 0xFFFFFFFF to 0 permitted.
REQ-027 mem_rd never asserted outside FETCH; at most one read in flight.
REQ-028 v0/a0 changes after acceptance have no effect on the in-progress service.

Reset
REQ-029 rst=1 forces IDLE immediately, independent of clk, mid-service included: stall, mem_rd, out_valid, done, err, halt = 0; mem_addr, out_data, ptr, code, counters = 0.
REQ-030 First posedge after rst release evaluates IDLE rules; an aborted service is not resumed.

Configuration
REQ-031 Macro SYSCALL_PRINT_INT_EN defined: code 1 (print_int) enters HEX, emits 8 uppercase hex ASCII digits of a0, MSB nibble first, each via EMIT handshake, then DONE; not defined: code 1 is unsupported (REQ-023) and HEX is absent.

Verification
REQ-032 v0=11, a0=0x41, syscall 1, out_ready=1 -> one byte 0x41, done pulse, stall low in DONE cycle only.
REQ-033 v0=4, a0=0x102, memory word 0x100=0x00434241 -> bytes 0x43 only ('C'), then NUL at 0x103 -> done; mem_addr=0x100 both reads.
REQ-034 v0=4, out_ready low 5 cycles on first byte -> out_valid/out_data stable 5 cycles, no extra mem_rd, string intact.
REQ-035 v0=10 -> halt=1 and stall=1 persist 100 cycles with syscall toggling; rst pulse clears halt.
REQ-036 v0=1, a0=0xDEADBEEF: with SYSCALL_PRINT_INT_EN -> "DEADBEEF" (0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46); without -> err and done, no bytes.
REQ-037 rst asserted mid-EMIT of string -> outputs zero asynchronously; later v0=99 -> err+done, no bytes.
